// File: rtl/logic_pipe_buf.sv
// logic_pipe_buf: DEPTH-entry valid/ready buffer of 4-state WIDTH-bit words.
// Optional X-detect on accepted pushes: define LOGIC_PIPE_XCHK_EN.
module logic_pipe_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lsb,
  output logic [CNT_W-1:0] count,
  output logic             x_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Readiness depends only on registered occupancy, never on out_ready.
  assign in_ready  = !rst && (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_lsb   = out_data[0];

  // Storage: popped slots are zeroed so an empty buffer shows 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop)  mem[rd_ptr] <= '0;
      if (push) mem[wr_ptr] <= in_data;
    end
  end

  // Pointers advance modulo DEPTH on their own handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push) wr_ptr <= nxt(wr_ptr);
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef LOGIC_PIPE_XCHK_EN
  // Sticky flag for any X/Z bit in an accepted word; word stored as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_err <= 1'b0;
    end else if (push && $isunknown(in_data)) begin
      x_err <= 1'b1;
`ifndef SYNTHESIS
      $error("logic_pipe_buf: X/Z push at %0t data=%b", $time, in_data);
`endif
    end
  end
`else
  assign x_err = 1'b0;
`endif

endmodule

// File: tb/tb_logic_pipe_buf.sv
// tb_logic_pipe_buf: scoreboard bench for DEPTH=2 and DEPTH=3 buffers.
// Expected words are queued on accepted push and compared on pop.
module tb_logic_pipe_buf;

  logic       clk;
  logic       rst;

  logic       iv2, ir2, ov2, or2, lsb2, xe2;
  logic [3:0] id2, od2;
  logic [1:0] cnt2;

  logic       iv3, ir3, ov3, or3, lsb3, xe3;
  logic [3:0] id3, od3;
  logic [1:0] cnt3;

  int checks;
  int errors;
  int rx3;

  logic [3:0] q2[$];
  logic [3:0] q3[$];

  logic_pipe_buf #(.WIDTH(4), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .out_lsb(lsb2), .count(cnt2), .x_err(xe2)
  );

  logic_pipe_buf #(.WIDTH(4), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .out_lsb(lsb3), .count(cnt3), .x_err(xe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "timeout");
  end

  task automatic step2(input logic v, input logic [3:0] d, input logic r);
    logic [3:0] e;
    iv2 = v; id2 = d; or2 = r;
    #1;
    if (ov2 && or2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb2_empty: got %b want none", od2);
      end else begin
        e = q2.pop_front();
        if (od2 !== e) begin
          errors++;
          $display("FAIL sb2_data: got %b want %b", od2, e);
        end
      end
    end
    if (iv2 && ir2) q2.push_back(id2);
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic v, input logic [3:0] d, input logic r);
    logic [3:0] e;
    iv3 = v; id3 = d; or3 = r;
    #1;
    if (ov3 && or3) begin
      checks++;
      rx3++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL sb3_empty: got %h want none", od3);
      end else begin
        e = q3.pop_front();
        if (od3 !== e) begin
          errors++;
          $display("FAIL sb3_data: got %h want %h", od3, e);
        end
      end
    end
    if (iv3 && ir3) q3.push_back(id3);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ir2, ir3} !== 2'b00) begin
      errors++;
      $display("FAIL rst_in_ready_hi: got %b want 00", {ir2, ir3});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ir2, ir3} !== 2'b11) begin
      errors++;
      $display("FAIL rst_in_ready_post: got %b want 11", {ir2, ir3});
    end
    checks++;
    if ({od2, ov2, cnt2, lsb2, xe2} !== 9'b0) begin
      errors++;
      $display("FAIL rst_state2: got %b want 0", {od2, ov2, cnt2, lsb2, xe2});
    end
    checks++;
    if ({od3, ov3, cnt3, lsb3, xe3} !== 9'b0) begin
      errors++;
      $display("FAIL rst_state3: got %b want 0", {od3, ov3, cnt3, lsb3, xe3});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    step2(1'b1, 4'hB, 1'b0);
    step2(1'b1, 4'h6, 1'b0);
    step2(1'b0, 4'h0, 1'b0);
    checks++;
    if ({cnt2, ir2, od2, lsb2} !== {2'd2, 1'b0, 4'hB, 1'b1}) begin
      errors++;
      $display("FAIL fill_full: got cnt=%0d ir=%b od=%h lsb=%b want 2 0 b 1",
               cnt2, ir2, od2, lsb2);
    end
    step2(1'b0, 4'h0, 1'b1);
    checks++;
    if ({od2, lsb2, cnt2} !== {4'h6, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL drain1: got od=%h lsb=%b cnt=%0d want 6 0 1", od2, lsb2, cnt2);
    end
    step2(1'b0, 4'h0, 1'b1);
    checks++;
    if ({ov2, od2, cnt2, lsb2} !== 8'b0) begin
      errors++;
      $display("FAIL drain2: got ov=%b od=%h cnt=%0d want 0 0 0", ov2, od2, cnt2);
    end
  endtask

  task automatic test_back_to_back();
    step3(1'b1, 4'h0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step3(1'b1, 4'(i), 1'b1);
      checks++;
      if (cnt3 !== 2'd1) begin
        errors++;
        $display("FAIL b2b_count[%0d]: got %0d want 1", i, cnt3);
      end
    end
    step3(1'b0, 4'h0, 1'b1);
    checks++;
    if (cnt3 !== 2'd0 || q3.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got cnt=%0d q=%0d want 0 0", cnt3, q3.size());
    end
  endtask

  task automatic test_wrap();
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    rx3 = 0;
    while ((sent < 7 || q3.size() != 0 || ov3) && cyc < 200) begin
      iv3 = (sent < 7);
      id3 = 4'(sent + 1);
      #1;
      if (iv3 && ir3) sent++;
      #0;
      step3((sent > 0) ? iv3 : iv3, id3, 1'($urandom_range(0, 1)));
      cyc++;
    end
    checks++;
    if (rx3 != 7 || q3.size() != 0 || cyc >= 200) begin
      errors++;
      $display("FAIL wrap: got rx=%0d q=%0d cyc=%0d want 7 0 <200",
               rx3, q3.size(), cyc);
    end
  endtask

  task automatic test_full_empty();
    for (int i = 0; i < 3; i++) step3(1'b1, 4'(8 + i), 1'b0);
    step3(1'b0, 4'h0, 1'b0);
    checks++;
    if ({cnt3, ir3} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL full: got cnt=%0d ir=%b want 3 0", cnt3, ir3);
    end
    step3(1'b1, 4'hF, 1'b1);
    checks++;
    if (cnt3 !== 2'd2) begin
      errors++;
      $display("FAIL full_pop_only: got %0d want 2", cnt3);
    end
    step3(1'b0, 4'h0, 1'b1);
    step3(1'b0, 4'h0, 1'b1);
    step3(1'b0, 4'h0, 1'b1);
    checks++;
    if ({cnt3, ov3, od3} !== 7'b0) begin
      errors++;
      $display("FAIL empty_pop: got cnt=%0d ov=%b od=%h want 0 0 0", cnt3, ov3, od3);
    end
    step3(1'b1, 4'h3, 1'b0);
    step3(1'b1, 4'h4, 1'b0);
    iv3 = 1'b1; id3 = 4'h5; or3 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iv3 = 1'b0;
    q3.delete();
    checks++;
    if ({cnt3, ov3, od3} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid: got cnt=%0d ov=%b od=%h want 0 0 0", cnt3, ov3, od3);
    end
  endtask

  task automatic test_xcheck();
    logic [3:0] xv;
    logic       exp;
    xv = 4'b1x01;
`ifdef LOGIC_PIPE_XCHK_EN
    exp = $isunknown(xv);
`else
    exp = 1'b0;
`endif
    step2(1'b1, xv, 1'b0);
    checks++;
    if (xe2 !== exp) begin
      errors++;
      $display("FAIL xerr_set: got %b want %b", xe2, exp);
    end
    step2(1'b0, 4'h0, 1'b1);
    step2(1'b1, 4'h2, 1'b1);
    step2(1'b0, 4'h0, 1'b1);
    checks++;
    if (xe2 !== exp) begin
      errors++;
      $display("FAIL xerr_hold: got %b want %b", xe2, exp);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q2.delete();
    checks++;
    if (xe2 !== 1'b0) begin
      errors++;
      $display("FAIL xerr_clr: got %b want 0", xe2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rx3 = 0;
    rst = 1'b1;
    iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    iv3 = 1'b0; id3 = '0; or3 = 1'b0;
    #1;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_full_empty();
    test_xcheck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
